// File: rtl/rx_acl_pkg.sv
// Shared constants, FSM encoding and key layout for the RX ACL lookup arbiter.
package rx_acl_pkg;

  localparam int unsigned ACL_KEY_WIDTH  = 144;
  localparam int unsigned ACL_RSLT_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } acl_state_e;

  localparam int unsigned DMAC_MSB  = 143;
  localparam int unsigned DMAC_LSB  = 96;
  localparam int unsigned SMAC_MSB  = 95;
  localparam int unsigned SMAC_LSB  = 48;
  localparam int unsigned TAG_MSB   = 47;
  localparam int unsigned TAG_LSB   = 16;
  localparam int unsigned ETYPE_MSB = 15;
  localparam int unsigned ETYPE_LSB = 0;

  function automatic logic [ACL_KEY_WIDTH-1:0] acl_key_pack(input logic [47:0] dmac,
                                                            input logic [47:0] smac,
                                                            input logic [31:0] tag,
                                                            input logic [15:0] etype);
    return {dmac, smac, tag, etype};
  endfunction

endpackage

// File: rtl/rx_acl_rr_arbiter.sv
// Round-robin pick among pending ports, searching upward from the rr pointer with wrap.
module rx_acl_rr_arbiter
  import rx_acl_pkg::*;
#(
  parameter int unsigned PORT_NUM = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [PORT_NUM-1:0] pending,
  input  logic [IDX_W-1:0]    rr,
  input  logic                grant_en,
  output logic [PORT_NUM-1:0] grant,
  output logic [IDX_W-1:0]    winner,
  output logic                grant_vld
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      idx = IDX_W'((int'(rr) + i) % int'(PORT_NUM));
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    grant_vld = found && grant_en;
    if (grant_vld) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/rx_acllookup_arbiter.sv
// Shares one ACL lookup engine between RX ports: one-entry key slot per port, round-robin
// grant, single outstanding lookup with timeout, result routed back to the owning port.
module rx_acllookup_arbiter
  import rx_acl_pkg::*;
#(
  parameter int unsigned          PORT_NUM     = 4,
  parameter int unsigned          KEY_WIDTH    = ACL_KEY_WIDTH,
  parameter int unsigned          RSLT_WIDTH   = ACL_RSLT_WIDTH,
  parameter int unsigned          TIMEOUT_CYC  = 255,
  parameter logic [RSLT_WIDTH-1:0] DEFAULT_RSLT = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [PORT_NUM*KEY_WIDTH-1:0] i_port_key_data,
  input  logic [PORT_NUM-1:0]           i_port_key_vld,
  output logic [PORT_NUM-1:0]           o_port_key_ovf,
  output logic [KEY_WIDTH-1:0]          o_acl_key_data,
  output logic                          o_acl_key_vld,
  input  logic                          i_acl_key_rdy,
  input  logic [RSLT_WIDTH-1:0]         i_acl_rslt_data,
  input  logic                          i_acl_rslt_vld,
  output logic [RSLT_WIDTH-1:0]         o_port_rslt_data,
  output logic [PORT_NUM-1:0]           o_port_rslt_vld,
  output logic                          o_timeout,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  acl_state_e           state_q;
  logic [PORT_NUM-1:0]  pending_q;
  logic [KEY_WIDTH-1:0] key_q [PORT_NUM];
  logic [IDX_W-1:0]     rr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [PORT_NUM-1:0]  grant;
  logic [IDX_W-1:0]     winner;
  logic                 grant_vld;

  rx_acl_rr_arbiter #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_rr_arbiter (
    .pending   (pending_q),
    .rr        (rr_q),
    .grant_en  (state_q == StIdle),
    .grant     (grant),
    .winner    (winner),
    .grant_vld (grant_vld)
  );

  assign o_busy = (state_q != StIdle);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= StIdle;
      pending_q        <= '0;
      rr_q             <= '0;
      owner_q          <= '0;
      cnt_q            <= '0;
      o_port_key_ovf   <= '0;
      o_acl_key_data   <= '0;
      o_acl_key_vld    <= 1'b0;
      o_port_rslt_data <= '0;
      o_port_rslt_vld  <= '0;
      o_timeout        <= 1'b0;
      for (int p = 0; p < int'(PORT_NUM); p++) key_q[p] <= '0;
    end else begin
      o_port_key_ovf  <= '0;
      o_port_rslt_vld <= '0;
      o_timeout       <= 1'b0;

      // A slot being granted this cycle frees up in time to take a new key.
      for (int p = 0; p < int'(PORT_NUM); p++) begin
        if (i_port_key_vld[p]) begin
          if (!pending_q[p] || grant[p]) begin
            key_q[p]     <= i_port_key_data[p*KEY_WIDTH +: KEY_WIDTH];
            pending_q[p] <= 1'b1;
          end else begin
            o_port_key_ovf[p] <= 1'b1;
          end
        end else if (grant[p]) begin
          pending_q[p] <= 1'b0;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            o_acl_key_data <= key_q[winner];
            o_acl_key_vld  <= 1'b1;
            owner_q        <= winner;
            rr_q           <= (winner == IDX_W'(PORT_NUM - 1)) ? '0 : winner + 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          if (i_acl_key_rdy) begin
            o_acl_key_vld <= 1'b0;
            cnt_q         <= '0;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_q <= cnt_q + 1'b1;
          if (i_acl_rslt_vld) begin
            o_port_rslt_vld[owner_q] <= 1'b1;
            o_port_rslt_data         <= i_acl_rslt_data;
            state_q                  <= StIdle;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            o_port_rslt_vld[owner_q] <= 1'b1;
            o_port_rslt_data         <= DEFAULT_RSLT;
            o_timeout                <= 1'b1;
            state_q                  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
